// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter in front of a single-port data memory.
// m0 is the CPU load/store port, m1 the debug/loader port. One access may be
// issued per cycle; a master can keep ownership across accesses with *_lock.
//
// Build option:
//   DM_ARB_RR_EN  defined   -> round-robin on contention in IDLE, tracked by a
//                              last-winner register (reset favours m0)
//                 undefined -> fixed priority, m0 wins every contention
//
// state | meaning
// IDLE  | no owner; either master may be granted
// OWN0  | m0 holds the memory (locked access); m1 stalls
// OWN1  | m1 holds the memory (locked access); m0 stalls
module dm_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t state_q, state_d;
    logic   rvalid0_q, rvalid0_d;
    logic   rvalid1_q, rvalid1_d;
    logic   gnt0, gnt1;
    logic   pick1;

`ifdef DM_ARB_RR_EN
    // last_q = 1 means m1 won most recently, so m0 is next in line
    logic last_q, last_d;

    // Contention winner is whichever master did not win last
    always_comb begin
        pick1 = ~last_q;
    end

    // Last-winner follows every grant, locked or not
    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    // Last-winner register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: m0 always takes a contended cycle
    always_comb begin
        pick1 = 1'b0;
    end
`endif

    // Grant decision and next-state; grants are masked during reset
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;

        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    gnt0 = ~pick1;
                    gnt1 = pick1;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
            end
            OWN0:    gnt0 = m0_req;
            OWN1:    gnt1 = m1_req;
            default: ;
        endcase

        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (gnt0 && m0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && m1_lock) begin
                    state_d = OWN1;
                end
            end
            // Ownership ends on an unlocked access or a cycle without request
            OWN0: begin
                if (!m0_req || !m0_lock) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!m1_req || !m1_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rvalid0_d = gnt0 & ~m0_we;
        rvalid1_d = gnt1 & ~m1_we;
    end

    // Memory command mux; all strobes idle when nothing is granted
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr & WORD_MASK;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
        end else if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr & WORD_MASK;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
        end
    end

    // Response side: rvalid is suppressed while reset is held so a read
    // issued just before reset never reports data
    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        m0_rvalid = rvalid0_q & ~rst;
        m1_rvalid = rvalid1_q & ~rst;
        m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
        m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
    end

    // State and read-pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

endmodule
